// File: rtl/gci_std_display_timing_gen_if.sv
// Read-stage and panel signals of the display timing generator.
// master = timing generator side, slave = read stage / panel side.
interface gci_std_display_timing_gen_if;
   logic       iDISP_ENA;
   logic       oRD_ENA;
   logic       oRD_SYNC;
   logic       iRD_VALID;
   logic [7:0] iRD_DATA_R;
   logic [7:0] iRD_DATA_G;
   logic [7:0] iRD_DATA_B;
   logic       oDISP_HSYNC;
   logic       oDISP_VSYNC;
   logic       oDISP_DE;
   logic [7:0] oDISP_R;
   logic [7:0] oDISP_G;
   logic [7:0] oDISP_B;
   logic       oUNDERFLOW;

   modport master (
      input  iDISP_ENA, iRD_VALID, iRD_DATA_R, iRD_DATA_G, iRD_DATA_B,
      output oRD_ENA, oRD_SYNC, oDISP_HSYNC, oDISP_VSYNC, oDISP_DE,
             oDISP_R, oDISP_G, oDISP_B, oUNDERFLOW
   );

   modport slave (
      output iDISP_ENA, iRD_VALID, iRD_DATA_R, iRD_DATA_G, iRD_DATA_B,
      input  oRD_ENA, oRD_SYNC, oDISP_HSYNC, oDISP_VSYNC, oDISP_DE,
             oDISP_R, oDISP_G, oDISP_B, oUNDERFLOW
   );
endinterface

// File: rtl/gci_std_display_timing_gen.sv
// Display raster timing: h/v counters, read requests, syncs, DE and registered pixel capture.
// Fixed 3-clock latency counter-to-pins; no backpressure, a missing pixel is shown black and flagged.
module gci_std_display_timing_gen #(
   parameter int P_H_AREA    = 640,
   parameter int P_H_FP      = 16,
   parameter int P_H_SYNC    = 96,
   parameter int P_H_BP      = 48,
   parameter int P_V_AREA    = 480,
   parameter int P_V_FP      = 10,
   parameter int P_V_SYNC    = 2,
   parameter int P_V_BP      = 33,
   parameter bit P_HSYNC_POL = 1'b0,
   parameter bit P_VSYNC_POL = 1'b0
) (
   input  logic                          iCLOCK,
   input  logic                          iRESET,
   gci_std_display_timing_gen_if.master  disp
);
   localparam int H_TOTAL = P_H_AREA + P_H_FP + P_H_SYNC + P_H_BP;
   localparam int V_TOTAL = P_V_AREA + P_V_FP + P_V_SYNC + P_V_BP;

   localparam logic [10:0] H_AREA     = 11'(P_H_AREA);
   localparam logic [10:0] H_SYNC_BEG = 11'(P_H_AREA + P_H_FP);
   localparam logic [10:0] H_SYNC_END = 11'(P_H_AREA + P_H_FP + P_H_SYNC);
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [9:0]  V_AREA     = 10'(P_V_AREA);
   localparam logic [9:0]  V_SYNC_BEG = 10'(P_V_AREA + P_V_FP);
   localparam logic [9:0]  V_SYNC_END = 10'(P_V_AREA + P_V_FP + P_V_SYNC);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        live;
   logic        rd_ena_q, rd_ena_d;
   logic        rd_sync_q, rd_sync_d;
   logic        slot_q, slot_d;
   logic        de_q, de_d;
   logic [1:0]  hs_pipe_q, hs_pipe_d;
   logic [1:0]  vs_pipe_q, vs_pipe_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic [23:0] rgb_q, rgb_d;
   logic        uf_q, uf_d;

   always_comb begin
      state_d = state_q;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      // Counter position is only meaningful in RUN cycles that are not being disabled.
      live    = (state_q == ST_RUN) && disp.iDISP_ENA;

      if (!disp.iDISP_ENA) begin
         state_d = ST_IDLE;
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_RUN;
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
         h_cnt_d = h_cnt_q + 11'd1;
      end

      rd_ena_d  = live && (h_cnt_q < H_AREA) && (v_cnt_q < V_AREA);
      rd_sync_d = live && (h_cnt_q == '0) && (v_cnt_q == '0);
      hs_pipe_d = {hs_pipe_q[0], live && (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)};
      vs_pipe_d = {vs_pipe_q[0], live && (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)};

      // slot_q marks the cycle in which the read stage answers the request issued a cycle earlier.
      slot_d  = rd_ena_q;
      de_d    = slot_q;
      hsync_d = hs_pipe_q[1] ? P_HSYNC_POL : ~P_HSYNC_POL;
      vsync_d = vs_pipe_q[1] ? P_VSYNC_POL : ~P_VSYNC_POL;
      rgb_d   = (slot_q && disp.iRD_VALID) ?
                {disp.iRD_DATA_R, disp.iRD_DATA_G, disp.iRD_DATA_B} : '0;
      uf_d    = uf_q || (slot_q && !disp.iRD_VALID);
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         state_q   <= ST_IDLE;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         rd_ena_q  <= 1'b0;
         rd_sync_q <= 1'b0;
         slot_q    <= 1'b0;
         de_q      <= 1'b0;
         hs_pipe_q <= '0;
         vs_pipe_q <= '0;
         hsync_q   <= ~P_HSYNC_POL;
         vsync_q   <= ~P_VSYNC_POL;
         rgb_q     <= '0;
         uf_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         rd_ena_q  <= rd_ena_d;
         rd_sync_q <= rd_sync_d;
         slot_q    <= slot_d;
         de_q      <= de_d;
         hs_pipe_q <= hs_pipe_d;
         vs_pipe_q <= vs_pipe_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         rgb_q     <= rgb_d;
         uf_q      <= uf_d;
      end
   end

   assign disp.oRD_ENA     = rd_ena_q;
   assign disp.oRD_SYNC    = rd_sync_q;
   assign disp.oDISP_DE    = de_q;
   assign disp.oDISP_HSYNC = hsync_q;
   assign disp.oDISP_VSYNC = vsync_q;
   assign disp.oDISP_R     = rgb_q[23:16];
   assign disp.oDISP_G     = rgb_q[15:8];
   assign disp.oDISP_B     = rgb_q[7:0];
   assign disp.oUNDERFLOW  = uf_q;
endmodule

// File: tb/tb_gci_std_display_timing_gen.sv
// Bench for the display timing generator on a shrunken 15x8 raster; two polarity variants run in lockstep.
module tb_gci_std_display_timing_gen;
   localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
   localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FR = HT * VT;

   typedef struct {
      int k;
      int rd_ena;
      int rd_sync;
      int de;
      int hs;
      int vs;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   gci_std_display_timing_gen_if bus_a ();
   gci_std_display_timing_gen_if bus_b ();

   assign bus_b.iDISP_ENA  = bus_a.iDISP_ENA;
   assign bus_b.iRD_VALID  = bus_a.iRD_VALID;
   assign bus_b.iRD_DATA_R = bus_a.iRD_DATA_R;
   assign bus_b.iRD_DATA_G = bus_a.iRD_DATA_G;
   assign bus_b.iRD_DATA_B = bus_a.iRD_DATA_B;

   gci_std_display_timing_gen #(
      .P_H_AREA(HA), .P_H_FP(HFP), .P_H_SYNC(HS), .P_H_BP(HBP),
      .P_V_AREA(VA), .P_V_FP(VFP), .P_V_SYNC(VS), .P_V_BP(VBP),
      .P_HSYNC_POL(1'b0), .P_VSYNC_POL(1'b0)
   ) dut_a (.iCLOCK(clk), .iRESET(rst), .disp(bus_a));

   gci_std_display_timing_gen #(
      .P_H_AREA(HA), .P_H_FP(HFP), .P_H_SYNC(HS), .P_H_BP(HBP),
      .P_V_AREA(VA), .P_V_FP(VFP), .P_V_SYNC(VS), .P_V_BP(VBP),
      .P_HSYNC_POL(1'b1), .P_VSYNC_POL(1'b1)
   ) dut_b (.iCLOCK(clk), .iRESET(rst), .disp(bus_b));

   // Reference model: raster position as a frame-relative cycle index n, outputs as delayed views of it.
   bit          m_run;
   int          m_n;
   bit          hl0, hl1;
   int          hn0, hn1;
   bit          e_rd_ena, e_rd_sync, e_de, e_hs, e_vs, e_uf;
   logic [23:0] e_rgb;

   function automatic bit is_active(input int n);
      return ((n % HT) < HA) && ((n / HT) < VA);
   endfunction

   function automatic bit in_hsync(input int n);
      return ((n % HT) >= HA + HFP) && ((n % HT) < HA + HFP + HS);
   endfunction

   function automatic bit in_vsync(input int n);
      return ((n / HT) >= VA + VFP) && ((n / HT) < VA + VFP + VS);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_run = 0; m_n = 0; hl0 = 0; hl1 = 0; hn0 = 0; hn1 = 0;
      e_rd_ena = 0; e_rd_sync = 0; e_de = 0; e_hs = 0; e_vs = 0; e_uf = 0;
      e_rgb = '0;
   endtask

   task automatic model_edge(input bit ena, input bit valid, input logic [23:0] data);
      bit live;
      live      = m_run && ena;
      e_rd_ena  = live && is_active(m_n);
      e_rd_sync = live && (m_n == 0);
      e_de      = hl1 && is_active(hn1);
      e_hs      = hl1 && in_hsync(hn1);
      e_vs      = hl1 && in_vsync(hn1);
      e_rgb     = (e_de && valid) ? data : 24'h0;
      if (e_de && !valid) e_uf = 1'b1;
      hl1 = hl0; hn1 = hn0;
      hl0 = live; hn0 = m_n;
      m_n   = live ? (m_n + 1) % FR : 0;
      m_run = ena;
   endtask

   task automatic compare_all();
      chk("rd_ena", bus_a.oRD_ENA, e_rd_ena);
      chk("rd_sync", bus_a.oRD_SYNC, e_rd_sync);
      chk("de", bus_a.oDISP_DE, e_de);
      chk("hsync", bus_a.oDISP_HSYNC, !e_hs);
      chk("vsync", bus_a.oDISP_VSYNC, !e_vs);
      chk("rgb", {bus_a.oDISP_R, bus_a.oDISP_G, bus_a.oDISP_B}, e_rgb);
      chk("underflow", bus_a.oUNDERFLOW, e_uf);
      chk("b_hsync", bus_b.oDISP_HSYNC, e_hs);
      chk("b_vsync", bus_b.oDISP_VSYNC, e_vs);
      chk("b_de", bus_b.oDISP_DE, e_de);
   endtask

   // Called at a falling edge: drive one cycle of inputs, advance the model, compare at the next falling edge.
   task automatic step(input bit ena, input bit valid, input logic [23:0] data);
      bus_a.iDISP_ENA = ena;
      bus_a.iRD_VALID = valid;
      {bus_a.iRD_DATA_R, bus_a.iRD_DATA_G, bus_a.iRD_DATA_B} = data;
      @(posedge clk);
      model_edge(ena, valid, data);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rd_ena"}, bus_a.oRD_ENA, 0);
      chk({tag, "_rd_sync"}, bus_a.oRD_SYNC, 0);
      chk({tag, "_de"}, bus_a.oDISP_DE, 0);
      chk({tag, "_rgb"}, {bus_a.oDISP_R, bus_a.oDISP_G, bus_a.oDISP_B}, 0);
      chk({tag, "_uf"}, bus_a.oUNDERFLOW, 0);
      chk({tag, "_hsync"}, bus_a.oDISP_HSYNC, 1);
      chk({tag, "_vsync"}, bus_a.oDISP_VSYNC, 1);
      chk({tag, "_b_hsync"}, bus_b.oDISP_HSYNC, 0);
      chk({tag, "_b_vsync"}, bus_b.oDISP_VSYNC, 0);
      chk({tag, "_b_uf"}, bus_b.oUNDERFLOW, 0);
   endtask

   // Called at a falling edge; reset lands between clock edges.
   task automatic async_reset(input int dly);
      #(dly);
      rst = 1'b1;
      #1;
      check_reset_vals("rst_now");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst_hold");
      rst = 1'b0;
   endtask

   initial begin
      vec_t        tbl[19];
      int          k, c_ena, c_sync, c_de, c_hs, c_vs, sync_a, sync_b, rise, gap;
      bit          found, de_prev, hs_prev;
      logic [23:0] pix;

      // k = edges after the enabling edge; hs/vs are the active-low variant's pin levels.
      tbl = '{
         '{0,   0, 0, 0, 1, 1}, '{1,   1, 1, 0, 1, 1}, '{2,   1, 0, 0, 1, 1},
         '{3,   1, 0, 1, 1, 1}, '{8,   1, 0, 1, 1, 1}, '{9,   0, 0, 1, 1, 1},
         '{11,  0, 0, 0, 1, 1}, '{13,  0, 0, 0, 0, 1}, '{15,  0, 0, 0, 0, 1},
         '{16,  1, 0, 0, 1, 1}, '{18,  1, 0, 1, 1, 1}, '{61,  0, 0, 0, 1, 1},
         '{78,  0, 0, 0, 1, 0}, '{88,  0, 0, 0, 0, 0}, '{107, 0, 0, 0, 1, 0},
         '{108, 0, 0, 0, 1, 1}, '{121, 1, 1, 0, 1, 1}, '{123, 1, 0, 1, 1, 1},
         '{135, 0, 0, 0, 0, 1}
      };

      bus_a.iDISP_ENA = 1'b0;
      bus_a.iRD_VALID = 1'b0;
      {bus_a.iRD_DATA_R, bus_a.iRD_DATA_G, bus_a.iRD_DATA_B} = 24'h0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_vals("por");
      rst = 1'b0;
      repeat (4) step(1'b0, 1'b1, 24'($urandom));

      k = 0;
      pix = 24'h000001;
      step(1'b1, 1'b1, pix);
      foreach (tbl[i]) begin
         while (k < tbl[i].k) begin
            pix = pix + 24'h010101;
            step(1'b1, 1'b1, pix);
            k++;
         end
         chk($sformatf("tbl%0d_rd_ena", i), bus_a.oRD_ENA, tbl[i].rd_ena);
         chk($sformatf("tbl%0d_rd_sync", i), bus_a.oRD_SYNC, tbl[i].rd_sync);
         chk($sformatf("tbl%0d_de", i), bus_a.oDISP_DE, tbl[i].de);
         chk($sformatf("tbl%0d_hsync", i), bus_a.oDISP_HSYNC, tbl[i].hs);
         chk($sformatf("tbl%0d_vsync", i), bus_a.oDISP_VSYNC, tbl[i].vs);
         chk($sformatf("tbl%0d_b_hsync", i), bus_b.oDISP_HSYNC, 1 - tbl[i].hs);
         chk($sformatf("tbl%0d_b_vsync", i), bus_b.oDISP_VSYNC, 1 - tbl[i].vs);
      end

      // Two-frame window: totals, sync period and DE-rise to HSYNC-fall distance.
      c_ena = 0; c_sync = 0; c_de = 0; c_hs = 0; c_vs = 0;
      sync_a = -1; sync_b = -1; rise = -1; gap = -1;
      de_prev = bus_a.oDISP_DE; hs_prev = bus_a.oDISP_HSYNC;
      for (int j = 0; j < 2 * FR; j++) begin
         step(1'b1, 1'b1, 24'($urandom));
         c_ena  += int'(bus_a.oRD_ENA);
         c_sync += int'(bus_a.oRD_SYNC);
         c_de   += int'(bus_a.oDISP_DE);
         c_hs   += int'(!bus_a.oDISP_HSYNC);
         c_vs   += int'(!bus_a.oDISP_VSYNC);
         if (bus_a.oRD_SYNC) begin sync_a = sync_b; sync_b = j; end
         if (bus_a.oDISP_DE && !de_prev) rise = j;
         if (!bus_a.oDISP_HSYNC && hs_prev && rise >= 0) gap = j - rise;
         de_prev = bus_a.oDISP_DE;
         hs_prev = bus_a.oDISP_HSYNC;
      end
      chk("frame_rd_ena", c_ena, 2 * HA * VA);
      chk("frame_rd_sync", c_sync, 2);
      chk("frame_de", c_de, 2 * HA * VA);
      chk("frame_hsync_low", c_hs, 2 * HS * VT);
      chk("frame_vsync_low", c_vs, 2 * VS * HT);
      chk("sync_period", sync_b - sync_a, FR);
      chk("de_to_hsync", gap, HA + HFP);

      // Alignment of the first pixel of a frame, then a single missing pixel.
      found = 0;
      for (int j = 0; j < 2 * FR && !found; j++) begin
         step(1'b1, 1'b1, 24'($urandom));
         found = bus_a.oRD_SYNC;
      end
      chk("align_sync_seen", found, 1);
      chk("align_rd_ena", bus_a.oRD_ENA, 1);
      step(1'b1, 1'b1, 24'($urandom));
      chk("align_de_before", bus_a.oDISP_DE, 0);
      step(1'b1, 1'b1, 24'h123456);
      chk("align_rgb", {bus_a.oDISP_R, bus_a.oDISP_G, bus_a.oDISP_B}, 24'h123456);
      chk("align_de", bus_a.oDISP_DE, 1);
      chk("uf_before", bus_a.oUNDERFLOW, 0);
      step(1'b1, 1'b0, 24'hABCDEF);
      chk("uf_pixel", {bus_a.oDISP_R, bus_a.oDISP_G, bus_a.oDISP_B}, 24'h0);
      chk("uf_de", bus_a.oDISP_DE, 1);
      chk("uf_set", bus_a.oUNDERFLOW, 1);
      repeat (2 * FR) step(1'b1, 1'b1, 24'($urandom));
      chk("uf_sticky", bus_a.oUNDERFLOW, 1);

      // Disable at line 1, pixel 5; re-enable restarts a frame.
      found = 0;
      for (int j = 0; j < 2 * FR && !found; j++) begin
         if (m_n == HT + 5) found = 1;
         else step(1'b1, 1'b1, 24'($urandom));
      end
      chk("dis_pos_seen", found, 1);
      step(1'b0, 1'b1, 24'($urandom));
      chk("dis_rd_ena", bus_a.oRD_ENA, 0);
      repeat (2) step(1'b0, 1'b1, 24'($urandom));
      chk("dis_de", bus_a.oDISP_DE, 0);
      c_sync = 0; c_de = 0;
      for (int j = 0; j < 30; j++) begin
         step(1'b0, 1'b1, 24'($urandom));
         c_sync += int'(bus_a.oRD_SYNC);
         c_de   += int'(bus_a.oDISP_DE);
      end
      chk("dis_no_sync", c_sync, 0);
      chk("dis_no_de", c_de, 0);
      chk("dis_uf_kept", bus_a.oUNDERFLOW, 1);
      step(1'b1, 1'b1, 24'($urandom));
      chk("reen_sync_edge", bus_a.oRD_SYNC, 0);
      step(1'b1, 1'b1, 24'($urandom));
      chk("reen_sync", bus_a.oRD_SYNC, 1);
      c_ena = int'(bus_a.oRD_ENA);
      repeat (FR - 1) begin
         step(1'b1, 1'b1, 24'($urandom));
         c_ena += int'(bus_a.oRD_ENA);
      end
      chk("reen_frame_rd_ena", c_ena, HA * VA);

      // Asynchronous reset in the middle of an active line.
      found = 0;
      for (int j = 0; j < 2 * FR && !found; j++) begin
         if (m_n == 2 * HT + 3) found = 1;
         else step(1'b1, 1'b1, 24'($urandom));
      end
      chk("pre_rst_de", bus_a.oDISP_DE, 1);
      async_reset(3);
      step(1'b1, 1'b1, 24'($urandom));
      chk("post_rst_sync_edge", bus_a.oRD_SYNC, 0);
      step(1'b1, 1'b1, 24'($urandom));
      chk("post_rst_sync", bus_a.oRD_SYNC, 1);
      chk("post_rst_uf", bus_a.oUNDERFLOW, 0);

      // Randomized traffic against the model, with one reset landing at a random point.
      for (int j = 0; j < 3000; j++) begin
         if (j == 1500) async_reset(int'($urandom_range(1, 3)));
         step($urandom_range(0, 199) != 0, $urandom_range(0, 39) != 0, 24'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
